// File: rtl/vector_data_memory.sv
// vector_data_memory: on-chip data memory for the pipeline Memory stage.
// Byte-lane writes go straight into the array. Reads are taken from the array
// on the accepting edge and then pass through an RD_LAT-deep shift pipeline.
// The last pipeline stage drives readData/readValid. That stage is loaded only
// when a read completes, so readData holds its last value between reads.
// Optional feature: define DMEM_BYPASS_EN so that in-flight reads pick up later
// writes to the same address. When it is undefined, in-flight reads keep the
// data they read at acceptance.
module vector_data_memory #(
    parameter int V      = 256,
    parameter int AW     = 14,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rden,
    input  logic            wren,
    input  logic [AW-1:0]   address,
    input  logic [V/8-1:0]  byteena,
    input  logic [V-1:0]    writeData,
    output logic [V-1:0]    readData,
    output logic            readValid,
    output logic            oobErr,
    output logic            collErr
);

    localparam int          NB      = V / 8;
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [V-1:0]      mem [DEPTH];
    logic [IW-1:0]     idx;
    logic              in_range;
    logic              wr_ok;
    logic              rd_acc;
    logic [V-1:0]      rd_word;

    logic [RD_LAT-1:0] pipe_vld;
    logic [V-1:0]      pipe_data [RD_LAT];
    logic [RD_LAT-1:0] load;
    logic [V-1:0]      shift_in [RD_LAT];
`ifdef DMEM_BYPASS_EN
    logic [AW-1:0]     pipe_addr [RD_LAT];
    logic [AW-1:0]     addr_in [RD_LAT];
`endif

    assign idx      = address[IW-1:0];
    assign in_range = ({1'b0, address} < DEPTH_W);
    assign wr_ok    = wren && in_range;
    // A read that collides with a write is dropped.
    assign rd_acc   = rden && !wren;

    // Array write: only the enabled byte lanes change. Out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (byteena[b]) mem[idx][8*b +: 8] <= writeData[8*b +: 8];
            end
        end
    end

    // Array read. An out-of-range read still returns a word, which is all zeros.
    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = mem[idx];
    end

    // Work out what enters each stage, and merge a bypassed write into entries still moving.
    always_comb begin
        for (int i = 0; i < RD_LAT; i++) begin
            load[i]     = 1'b0;
            shift_in[i] = '0;
`ifdef DMEM_BYPASS_EN
            addr_in[i]  = '0;
`endif
        end
        load[0]     = rd_acc;
        shift_in[0] = rd_word;
`ifdef DMEM_BYPASS_EN
        addr_in[0]  = address;
`endif
        for (int i = 1; i < RD_LAT; i++) begin
            load[i]     = pipe_vld[i-1];
            shift_in[i] = pipe_data[i-1];
`ifdef DMEM_BYPASS_EN
            addr_in[i]  = pipe_addr[i-1];
            if (wr_ok && pipe_vld[i-1] && (pipe_addr[i-1] == address)) begin
                for (int b = 0; b < NB; b++) begin
                    if (byteena[b]) shift_in[i][8*b +: 8] = writeData[8*b +: 8];
                end
            end
`endif
        end
    end

    // Read pipeline shift. A reset discards in-flight reads. A stage keeps its data while it is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data[i] <= '0;
`ifdef DMEM_BYPASS_EN
                pipe_addr[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= load[i];
                if (load[i]) begin
                    pipe_data[i] <= shift_in[i];
`ifdef DMEM_BYPASS_EN
                    pipe_addr[i] <= addr_in[i];
`endif
                end
            end
        end
    end

    // Sticky error flags. Only a reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oobErr  <= 1'b0;
            collErr <= 1'b0;
        end else begin
            if ((rden || wren) && !in_range) oobErr <= 1'b1;
            if (rden && wren) collErr <= 1'b1;
        end
    end

    assign readValid = pipe_vld[RD_LAT-1];
    assign readData  = pipe_data[RD_LAT-1];

endmodule

// File: tb/tb_vector_data_memory.sv
// Directed bench for vector_data_memory. It uses a table of read vectors with
// hand-computed data, plus hand-written sequences for the multi-cycle cases:
// back-to-back reads, collision, write-under-read and mid-flight reset.
// A read requested before edge e is expected to be seen by the consumer on
// edge e+RD_LAT. Here that means the outputs are high at the RD_LAT-th falling
// edge after the request is driven.
module tb_vector_data_memory;

    localparam int V      = 256;
    localparam int AW     = 14;
    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 2;
    localparam int NB     = V / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rden = 1'b0;
    logic          wren = 1'b0;
    logic [AW-1:0] address = '0;
    logic [NB-1:0] byteena = '0;
    logic [V-1:0]  writeData = '0;
    logic [V-1:0]  readData;
    logic          readValid;
    logic          oobErr;
    logic          collErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [V-1:0]  exp;
        string         name;
    } vec_t;

    vec_t vecs [7];

    vector_data_memory #(.V(V), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rden      (rden),
        .wren      (wren),
        .address   (address),
        .byteena   (byteena),
        .writeData (writeData),
        .readData  (readData),
        .readValid (readValid),
        .oobErr    (oobErr),
        .collErr   (collErr)
    );

    always #5 clk = ~clk;

    function automatic logic [V-1:0] pat(input int k);
        logic [V-1:0] p;
        for (int w = 0; w < 8; w++) p[32*w +: 32] = 32'h0101_0101 * 32'(k + 1) + 32'(w);
        return p;
    endfunction

    task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [V-1:0] d);
        @(negedge clk);
        wren = 1'b1; address = a; byteena = be; writeData = d;
        @(negedge clk);
        wren = 1'b0; byteena = '0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [V-1:0] exp, input string name);
        @(negedge clk);
        rden = 1'b1; address = a;
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) rden = 1'b0;
            chk({name, "_valid"}, V'(readValid), V'(k == RD_LAT));
            if (k == RD_LAT) chk({name, "_data"}, readData, exp);
        end
    endtask

    logic [V-1:0] ramp, mix7, dat9, dat_a, dat_b, exp5;

    initial begin
        for (int i = 0; i < NB; i++) ramp[8*i +: 8] = 8'(i);
        mix7  = {{(V-32){1'b1}}, 32'h0};
        dat9  = {8{32'hDEAD_BEEF}};
        dat_a = {8{32'hAAAA_5555}};
        dat_b = {8{32'h1234_5678}};
`ifdef DMEM_BYPASS_EN
        exp5 = dat_b;
`else
        exp5 = dat_a;
`endif
        vecs[0] = '{addr: 14'd5,    exp: ramp,   name: "rd_ramp5"};
        vecs[1] = '{addr: 14'd7,    exp: mix7,   name: "rd_partial7"};
        vecs[2] = '{addr: 14'd6,    exp: pat(6), name: "rd_be0_6"};
        vecs[3] = '{addr: 14'd9,    exp: dat9,   name: "rd_coll9"};
        vecs[4] = '{addr: 14'd1024, exp: '0,     name: "rd_oob1024"};
        vecs[5] = '{addr: 14'd0,    exp: pat(0), name: "rd_addr0"};
        vecs[6] = '{addr: 14'd1023, exp: pat(9), name: "rd_top1023"};

        // Reset state
        #12;
        chk("rst_data",  readData, '0);
        chk("rst_valid", V'(readValid), '0);
        chk("rst_oob",   V'(oobErr), '0);
        chk("rst_coll",  V'(collErr), '0);
        @(negedge clk);
        rst = 1'b1;

        // Preload the array
        do_write(14'd5, '1, ramp);
        do_write(14'd7, '1, '1);
        do_write(14'd7, 32'h0000_000F, '0);
        do_write(14'd6, '1, pat(6));
        do_write(14'd6, '0, dat9);
        for (int k = 0; k < 4; k++) do_write(14'(k), '1, pat(k));
        do_write(14'd4, '1, dat_a);
        do_write(14'd1023, '1, pat(9));
        chk("oob_clean",  V'(oobErr), '0);
        chk("coll_clean", V'(collErr), '0);

        // Back-to-back reads of addresses 0..3
        for (int k = 0; k <= 3 + RD_LAT + 1; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                chk($sformatf("b2b_valid%0d", k), V'(readValid), V'(k >= RD_LAT && k <= RD_LAT + 3));
                if (k >= RD_LAT && k <= RD_LAT + 3)
                    chk($sformatf("b2b_data%0d", k), readData, pat(k - RD_LAT));
            end
            rden    = (k <= 3);
            address = 14'(k);
        end
        rden = 1'b0;

        // Collision: the write lands and the read is dropped
        @(negedge clk);
        rden = 1'b1; wren = 1'b1; address = 14'd9; byteena = '1; writeData = dat9;
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            @(negedge clk);
            rden = 1'b0; wren = 1'b0;
            chk($sformatf("coll_novalid%0d", k), V'(readValid), '0);
        end
        chk("coll_flag", V'(collErr), 1);
        chk("coll_nooob", V'(oobErr), '0);

        // Out-of-range write to 1029 must not alias onto address 5
        do_write(14'd1029, '1, dat_b);
        chk("oob_wr_flag", V'(oobErr), 1);

        // Table-driven reads
        for (int i = 0; i < 7; i++) do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
        chk("oob_sticky", V'(oobErr), 1);
        chk("coll_sticky", V'(collErr), 1);

        // Write to address 4 lands while a read of address 4 is in flight
        @(negedge clk);
        rden = 1'b1; address = 14'd4;
        @(negedge clk);
        rden = 1'b0; wren = 1'b1; byteena = '1; writeData = dat_b;
        chk("wur_pend", V'(readValid), '0);
        @(negedge clk);
        wren = 1'b0; byteena = '0;
        chk("wur_valid", V'(readValid), 1);
        chk("wur_data", readData, exp5);
        @(negedge clk);
        chk("wur_single", V'(readValid), '0);
        chk("wur_hold", readData, exp5);
        do_read(14'd4, dat_b, "rd_after_wur");

        // Reset while reads are in flight
        @(negedge clk);
        rden = 1'b1; address = 14'd0;
        @(negedge clk);
        address = 14'd1;
        #2;
        rst = 1'b0; rden = 1'b0;
        #1;
        chk("mid_rst_data",  readData, '0);
        chk("mid_rst_valid", V'(readValid), '0);
        chk("mid_rst_oob",   V'(oobErr), '0);
        chk("mid_rst_coll",  V'(collErr), '0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= RD_LAT + 2; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_novalid%0d", k), V'(readValid), '0);
        end
        do_read(14'd5, ramp, "rd_post_rst5");
        do_read(14'd4, dat_b, "rd_post_rst4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
